// File: rtl/ahb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ahb_arbiter_pkg
// Shared definitions for the AHB bus arbiter:
//   - default master count / index width (overridable macros)
//   - AHB Htrans and Hburst encodings
//   - arbiter state enumeration and its legacy-compatible constants
//   - helper returning the remaining-beat count loaded at a burst start
// -----------------------------------------------------------------------------
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif

`ifndef MASTER_WIDTH
`define MASTER_WIDTH 2
`endif

package ahb_arbiter_pkg;

   // Htrans encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Hburst encodings
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Beat counter must hold up to 15 (INCR16 length minus one)
   localparam int BEAT_W = 4;

   // Arbiter states
   typedef enum logic [1:0] {
      ARB_PARK   = 2'b00,
      ARB_OWN    = 2'b01,
      ARB_LOCKED = 2'b10
   } arb_state_e;

   localparam logic [1:0] ST_PARK   = ARB_PARK;
   localparam logic [1:0] ST_OWN    = ARB_OWN;
   localparam logic [1:0] ST_LOCKED = ARB_LOCKED;

   // Remaining beats after the NONSEQ of a burst. Wrapping bursts count as
   // their incrementing equivalent; SINGLE and undefined-length INCR never
   // hold the bus through the counter.
   function automatic logic [BEAT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
      logic [BEAT_W-1:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = BEAT_W'(3);
         HBURST_WRAP8,  HBURST_INCR8:  beats = BEAT_W'(7);
         HBURST_WRAP16, HBURST_INCR16: beats = BEAT_W'(15);
         HBURST_SINGLE, HBURST_INCR:   beats = '0;
         default:                      beats = '0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_arbiter_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search. Candidates are examined in the order
// ptr_i+1, ptr_i+2, ... wrapping at NUM_REQ, ending at ptr_i itself, so the
// previous winner has the lowest priority.
// Ports:
//   req_i     [NUM_REQ]  request vector
//   ptr_i     [IDX_W]    index of the last granted requester
//   valid_o              at least one request present
//   winner_o  [NUM_REQ]  one-hot winner (all zero when valid_o = 0)
//   index_o   [IDX_W]    winner index (zero when valid_o = 0)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [NUM_REQ-1:0] winner_o,
   output logic [IDX_W-1:0]   index_o
);

   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_req;

   // Search slot gi looks at requester (ptr_i + 1 + gi) mod NUM_REQ. The sum
   // never reaches 2*NUM_REQ, so a single conditional subtract is the modulo.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [31:0] sum;
      assign sum           = 32'(ptr_i) + 32'(gi) + 32'd1;
      assign cand_idx[gi]  = (sum >= 32'(NUM_REQ)) ? IDX_W'(sum - 32'(NUM_REQ))
                                                   : IDX_W'(sum);
      assign cand_req[gi]  = req_i[cand_idx[gi]];
   end

   always_comb begin
      valid_o  = 1'b0;
      index_o  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!valid_o && cand_req[k]) begin
            valid_o = 1'b1;
            index_o = cand_idx[k];
         end
      end
      winner_o = '0;
      if (valid_o) begin
         winner_o[index_o] = 1'b1;
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
// Round-robin AHB bus arbiter with bus parking, fixed-length burst hold-off
// and locked-transfer support.
// Ports:
//   Hclk       in   system clock, rising edge
//   Hresetn    in   asynchronous reset, active high
//   Hbusreq    in   [NUM_MASTERS] per-master bus request
//   Hlock      in   [NUM_MASTERS] per-master lock request (qualified by Hbusreq)
//   Htrans     in   [2] transfer type of the address-phase owner
//   Hburst     in   [3] burst type of the address-phase owner
//   Hready     in   transfer ready; every state change waits for it
//   Hgrant     out  [NUM_MASTERS] one-hot grant
//   Hmaster    out  [MASTER_WIDTH] address-phase owner index
//   Hmastlock  out  current address phase belongs to a locked sequence
// -----------------------------------------------------------------------------
module ahb_arbiter
   import ahb_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS    = `NUM_MASTERS,
   parameter int MASTER_WIDTH   = `MASTER_WIDTH,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                    Hclk,
   input  logic                    Hresetn,
   input  logic [NUM_MASTERS-1:0]  Hbusreq,
   input  logic [NUM_MASTERS-1:0]  Hlock,
   input  logic [1:0]              Htrans,
   input  logic [2:0]              Hburst,
   input  logic                    Hready,
   output logic [NUM_MASTERS-1:0]  Hgrant,
   output logic [MASTER_WIDTH-1:0] Hmaster,
   output logic                    Hmastlock
);

   localparam logic [MASTER_WIDTH-1:0] DEF_IDX   = MASTER_WIDTH'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0]  DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [1:0]              state_q,     state_d;
   logic [NUM_MASTERS-1:0]  grant_q,     grant_d;
   logic [MASTER_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic [MASTER_WIDTH-1:0] last_q,      last_d;
   logic [BEAT_W-1:0]       beat_q,      beat_d;
   logic [MASTER_WIDTH-1:0] master_q;
   logic                    mastlock_q;

   logic                    pick_valid;
   logic [NUM_MASTERS-1:0]  pick_winner;
   logic [MASTER_WIDTH-1:0] pick_idx;

   logic                    owner_lock;
   logic                    rearb;

   rr_priority_picker #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (MASTER_WIDTH)
   ) u_picker (
      .req_i    (Hbusreq),
      .ptr_i    (last_q),
      .valid_o  (pick_valid),
      .winner_o (pick_winner),
      .index_o  (pick_idx)
   );

   // The granted master wants (or keeps) a locked sequence
   assign owner_lock = Hlock[grant_idx_q] & Hbusreq[grant_idx_q];

   // Beat counter tracks the remaining beats of a fixed-length burst. It is
   // evaluated for the current edge so that the NONSEQ which opens a burst
   // already blocks re-arbitration on the very edge it is sampled.
   always_comb begin
      beat_d = beat_q;
      case (Htrans)
         HTRANS_IDLE:   beat_d = '0;
         HTRANS_BUSY:   beat_d = beat_q;
         HTRANS_NONSEQ: beat_d = burst_beats_m1(Hburst);
         HTRANS_SEQ:    if (beat_q != '0) beat_d = beat_q - BEAT_W'(1);
         default:       beat_d = beat_q;
      endcase
   end

   // Grant / state decision for an Hready=1 edge
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      last_d      = last_q;
      rearb       = 1'b0;

      if (state_q == ST_LOCKED) begin
         // Lock is released as soon as the owner drops Hlock, burst or not
         rearb = !owner_lock;
      end else if (beat_d == '0) begin
         if (owner_lock) begin
            // The master already holding the grant keeps it, now locked
            state_d = ST_LOCKED;
            last_d  = grant_idx_q;
         end else begin
            rearb = 1'b1;
         end
      end

      if (rearb) begin
         if (pick_valid) begin
            state_d     = ST_OWN;
            grant_d     = pick_winner;
            grant_idx_d = pick_idx;
            last_d      = pick_idx;
         end else begin
            // Nobody requests: park the default master, keep the RR pointer
            state_d     = ST_PARK;
            grant_d     = DEF_GRANT;
            grant_idx_d = DEF_IDX;
         end
      end
   end

   always_ff @(posedge Hclk or posedge Hresetn) begin
      if (Hresetn) begin
         state_q     <= ST_PARK;
         grant_q     <= DEF_GRANT;
         grant_idx_q <= DEF_IDX;
         last_q      <= DEF_IDX;
         beat_q      <= '0;
         master_q    <= DEF_IDX;
         mastlock_q  <= 1'b0;
      end else if (Hready) begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         // Address phase is handed to whoever held the grant up to this edge
         master_q    <= grant_idx_q;
         mastlock_q  <= (state_q == ST_LOCKED);
      end
   end

   assign Hgrant    = grant_q;
   assign Hmaster   = master_q;
   assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_ahb_arbiter;
   import ahb_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int MW  = 2;
   localparam int DEF = 0;

   logic          Hclk    = 1'b0;
   logic          Hresetn = 1'b1;
   logic [N-1:0]  Hbusreq = '0;
   logic [N-1:0]  Hlock   = '0;
   logic [1:0]    Htrans  = HTRANS_IDLE;
   logic [2:0]    Hburst  = HBURST_SINGLE;
   logic          Hready  = 1'b1;
   logic [N-1:0]  Hgrant;
   logic [MW-1:0] Hmaster;
   logic          Hmastlock;

   always #5 Hclk = ~Hclk;

   ahb_arbiter #(
      .NUM_MASTERS    (N),
      .MASTER_WIDTH   (MW),
      .DEFAULT_MASTER (DEF)
   ) dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .Hbusreq   (Hbusreq),
      .Hlock     (Hlock),
      .Htrans    (Htrans),
      .Hburst    (Hburst),
      .Hready    (Hready),
      .Hgrant    (Hgrant),
      .Hmaster   (Hmaster),
      .Hmastlock (Hmastlock)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: who holds the grant, who owns the address phase,
   // whether the bus is locked, how many burst beats remain, last winner.
   int m_grant, m_master, m_last, m_beats;
   bit m_locked, m_mastlock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int burst_len(input logic [2:0] b);
      case (b)
         3'b010, 3'b011: return 4;
         3'b100, 3'b101: return 8;
         3'b110, 3'b111: return 16;
         default:        return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_grant = DEF; m_master = DEF; m_last = DEF;
      m_beats = 0; m_locked = 0; m_mastlock = 0;
   endtask

   task automatic model_edge();
      int  nb;
      int  ng;
      bit  owner_locks;
      bit  arbitrate;
      if (Hresetn) begin
         model_reset();
         return;
      end
      if (!Hready) return;
      case (Htrans)
         HTRANS_IDLE:   nb = 0;
         HTRANS_NONSEQ: nb = burst_len(Hburst) - 1;
         HTRANS_SEQ:    nb = (m_beats > 0) ? m_beats - 1 : 0;
         default:       nb = m_beats;
      endcase
      owner_locks = Hlock[m_grant] && Hbusreq[m_grant];
      arbitrate   = 0;
      ng          = m_grant;
      m_master    = m_grant;
      m_mastlock  = m_locked;
      if (m_locked) begin
         arbitrate = !owner_locks;
      end else if (nb == 0) begin
         if (owner_locks) begin
            m_locked = 1;
            m_last   = m_grant;
         end else begin
            arbitrate = 1;
         end
      end
      if (arbitrate) begin
         m_locked = 0;
         ng = DEF;
         for (int k = 1; k <= N; k++) begin
            if (Hbusreq[(m_last + k) % N]) begin
               ng = (m_last + k) % N;
               m_last = ng;
               break;
            end
         end
      end
      m_grant = ng;
      m_beats = nb;
   endtask

   task automatic check_model();
      check("grant",     Hgrant,           32'd1 << m_grant);
      check("onehot",    $onehot(Hgrant),  32'd1);
      check("hmaster",   Hmaster,          m_master);
      check("hmastlock", Hmastlock,        m_mastlock);
   endtask

   task automatic step();
      @(posedge Hclk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
      Hbusreq = req; Hlock = lck; Htrans = tr; Hburst = bu; Hready = rdy;
   endtask

   initial begin
      model_reset();

      // Reset held, then released with no requests
      repeat (2) step();
      Hresetn = 1'b0;
      step(); step();
      check("rst_grant",    Hgrant,    32'b0001);
      check("rst_hmaster",  Hmaster,   32'd0);
      check("rst_mastlock", Hmastlock, 32'd0);

      // All masters request SINGLE transfers: grants rotate, Hmaster lags
      drive(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("rr_grant_%0d", k),   Hgrant,  32'd1 << (k % N));
         check($sformatf("rr_hmaster_%0d", k), Hmaster, 32'((k - 1) % N));
      end

      // Master 1 INCR4 with master 2 waiting
      drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step(); step();
      check("park_after_rr", Hgrant, 32'b0001);
      drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step();
      check("m1_granted", Hgrant, 32'b0010);
      step();
      check("m1_owner", Hmaster, 32'd1);
      drive(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
      step();
      check("incr4_beat1", Hgrant, 32'b0010);
      Htrans = HTRANS_SEQ;
      step();
      check("incr4_beat2", Hgrant, 32'b0010);
      step();
      check("incr4_beat3", Hgrant, 32'b0010);
      step();
      check("incr4_handover", Hgrant, 32'b0100);
      check("incr4_hmaster",  Hmaster, 32'd1);

      // Master 3 INCR8 with a 3-cycle wait state during beat 2
      drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step();
      drive(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step(); step();
      check("m3_owner", Hmaster, 32'd3);
      drive(4'b1001, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
      step();
      Htrans = HTRANS_SEQ;
      step();
      Hready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("wait_grant_%0d", k),   Hgrant,  32'b1000);
         check($sformatf("wait_hmaster_%0d", k), Hmaster, 32'd3);
      end
      Hready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("incr8_hold_%0d", k), Hgrant, 32'b1000);
      end
      step();
      check("incr8_handover", Hgrant, 32'b0001);

      // Master 0 locked while everybody else requests
      drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step(); step();
      drive(4'b1111, 4'b0001, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      step();
      check("lock_entry_grant", Hgrant, 32'b0001);
      Htrans = HTRANS_NONSEQ;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("lock_grant_%0d", k),    Hgrant,    32'b0001);
         check($sformatf("lock_mastlock_%0d", k), Hmastlock, 32'd1);
      end
      Hlock = 4'b0000;
      step();
      check("unlock_grant", Hgrant, 32'b0010);
      step();
      check("unlock_mastlock", Hmastlock, 32'd0);
      check("unlock_hmaster",  Hmaster,   32'd1);

      // Asynchronous reset in the middle of an INCR16
      drive(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1);
      step();
      drive(4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1);
      repeat (3) step();
      check("incr16_hold", Hgrant, 32'b0100);
      #3;
      Hresetn = 1'b1;
      #1;
      model_reset();
      check("async_rst_grant",    Hgrant,    32'b0001);
      check("async_rst_hmaster",  Hmaster,   32'd0);
      check("async_rst_mastlock", Hmastlock, 32'd0);
      step();
      Hresetn = 1'b0;
      drive(4'b1111, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1);
      step();
      check("post_rst_grant", Hgrant, 32'b0010);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] lk;
         for (int m = 0; m < N; m++) lk[m] = ($urandom_range(0, 5) == 0);
         drive(N'($urandom), lk, 2'($urandom), 3'($urandom),
               ($urandom_range(0, 4) != 0));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
